// File: rtl/spi_pkg.sv
// spi_pkg: shared state/mode types and width helpers for the SPI master.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   // Width of the slave-select index; never narrower than one bit.
   function automatic int sel_width(input int num_ss);
      if (num_ss > 32'sd1) begin
         return $clog2(num_ss);
      end else begin
         return 32'sd1;
      end
   endfunction

   // Edge counter holds 0..2*data_w without wrapping inside a frame.
   function automatic int edge_cnt_width(input int data_w);
      return $clog2(32'sd2 * data_w) + 32'sd1;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter and SCLK toggle. While enabled it emits a
// tick every div+1 cycles; with edge_en set the tick also toggles SCLK and is
// reported as a leading or trailing edge relative to the idle level.
module spi_clk_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             edge_en,
   input  logic             idle_lvl,
   input  logic [DIV_W-1:0] div,
   output logic             sclk,
   output logic             tick,
   output logic             lead_stb,
   output logic             trail_stb
);

   logic [DIV_W-1:0] cnt_r;
   logic             sclk_r;
   logic             tick_s;
   logic             toggle_s;

   assign tick_s    = en && (cnt_r == div);
   assign toggle_s  = tick_s && edge_en;
   assign tick      = tick_s;
   assign sclk      = sclk_r;
   assign lead_stb  = toggle_s && (sclk_r == idle_lvl);
   assign trail_stb = toggle_s && (sclk_r != idle_lvl);

   // Half-period counter: restarts on every tick and while disabled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (!en || tick_s) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + DIV_W'(1'b1);
      end
   end

   // SCLK register: parks at the idle level when disabled, toggles on edges.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_r <= 1'b0;
      end else if (!en) begin
         sclk_r <= idle_lvl;
      end else if (toggle_s) begin
         sclk_r <= ~sclk_r;
      end else begin
         sclk_r <= sclk_r;
      end
   end

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master, MSB-first, runtime CPOL/CPHA, SCLK divider and
// one-hot active-low slave selects. One frame per accepted start pulse.
// Build option: define SPI_LOOPBACK_EN to add a 'loopback' input that makes
// the sampler capture the internal mosi instead of the miso pin.
module spi_master_cfg
   import spi_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int NUM_SS = 4,
   parameter int DIV_W  = 8,
   parameter int SEL_W  = sel_width(NUM_SS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] wdata,
   input  logic [SEL_W-1:0]  ss_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DIV_W-1:0]  clk_div,
`ifdef SPI_LOOPBACK_EN
   input  logic              loopback,
`endif
   output logic              rdy,
   output logic [DATA_W-1:0] rdata,
   output logic              rx_valid,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_SS-1:0] ss_n
);

   localparam int                ECNT_W    = edge_cnt_width(DATA_W);
   localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(32'd2 * DATA_W - 32'd1);
   localparam logic [SEL_W:0]    NUM_SS_C  = (SEL_W + 1)'(NUM_SS);

   spi_state_t        state_r, state_nxt_s;
   spi_mode_t         mode_r;
   logic [DIV_W-1:0]  div_r;
   logic [DATA_W-1:0] tx_r, rx_r, rdata_r;
   logic [ECNT_W-1:0] edge_cnt_r;
   logic [NUM_SS-1:0] ss_n_r, sel_mask_s;
   logic              rdy_r, rx_valid_r, mosi_r;
   logic              accept_s, done_s, en_s, edge_en_s, idle_lvl_s, sel_ok_s;
   logic              tick_s, lead_stb_s, trail_stb_s, any_edge_s, last_edge_s;
   logic              sample_stb_s, drive_stb_s, sample_bit_s;

`ifdef SPI_LOOPBACK_EN
   logic loopback_r;
   assign sample_bit_s = loopback_r ? mosi_r : miso;
`else
   assign sample_bit_s = miso;
`endif

   assign sel_ok_s     = ({1'b0, ss_sel} < NUM_SS_C);
   assign sel_mask_s   = NUM_SS'(1'b1) << ss_sel;
   assign en_s         = (state_r != IDLE);
   assign edge_en_s    = (state_r == SETUP) || (state_r == XFER);
   assign any_edge_s   = lead_stb_s || trail_stb_s;
   assign last_edge_s  = (edge_cnt_r == LAST_EDGE);
   assign sample_stb_s = mode_r.cpha ? trail_stb_s : lead_stb_s;
   assign drive_stb_s  = mode_r.cpha ? lead_stb_s  : trail_stb_s;

   assign rdy      = rdy_r;
   assign rdata    = rdata_r;
   assign rx_valid = rx_valid_r;
   assign mosi     = mosi_r;
   assign ss_n     = ss_n_r;

   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en_s),
      .edge_en   (edge_en_s),
      .idle_lvl  (idle_lvl_s),
      .div       (div_r),
      .sclk      (sclk),
      .tick      (tick_s),
      .lead_stb  (lead_stb_s),
      .trail_stb (trail_stb_s)
   );

   // Idle SCLK level; an accepted frame's polarity applies from SETUP on.
   always_comb begin
      if (accept_s) begin
         idle_lvl_s = cpol;
      end else begin
         idle_lvl_s = mode_r.cpol;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode plus accept/complete strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && sel_ok_s) begin
               accept_s    = 1'b1;
               state_nxt_s = SETUP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SETUP: begin
            if (lead_stb_s) begin
               state_nxt_s = XFER;
            end else begin
               state_nxt_s = SETUP;
            end
         end
         XFER: begin
            if (any_edge_s && last_edge_s) begin
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = XFER;
            end
         end
         HOLD: begin
            if (tick_s) begin
               done_s      = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Datapath: latch the request, shift on SCLK edges, publish on completion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_r     <= '0;
         div_r      <= '0;
         tx_r       <= '0;
         rx_r       <= '0;
         rdata_r    <= '0;
         edge_cnt_r <= '0;
         ss_n_r     <= '1;
         rdy_r      <= 1'b1;
         rx_valid_r <= 1'b0;
         mosi_r     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
         loopback_r <= 1'b0;
`endif
      end else begin
         rdy_r      <= (state_nxt_s == IDLE);
         rx_valid_r <= 1'b0;
         if (accept_s) begin
            mode_r     <= '{cpol: cpol, cpha: cpha};
            div_r      <= clk_div;
            ss_n_r     <= ~sel_mask_s;
            rx_r       <= '0;
            edge_cnt_r <= '0;
`ifdef SPI_LOOPBACK_EN
            loopback_r <= loopback;
`endif
            // CPHA=0 presents the MSB during SETUP; CPHA=1 drives it on edge 0.
            if (cpha) begin
               tx_r <= wdata;
            end else begin
               tx_r   <= {wdata[DATA_W-2:0], 1'b0};
               mosi_r <= wdata[DATA_W-1];
            end
         end else if (done_s) begin
            ss_n_r     <= '1;
            rdata_r    <= rx_r;
            rx_valid_r <= 1'b1;
         end else begin
            if (drive_stb_s) begin
               mosi_r <= tx_r[DATA_W-1];
               tx_r   <= {tx_r[DATA_W-2:0], 1'b0};
            end
            if (sample_stb_s) begin
               rx_r <= {rx_r[DATA_W-2:0], sample_bit_s};
            end
            if (any_edge_s) begin
               edge_cnt_r <= edge_cnt_r + ECNT_W'(1'b1);
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed frames with an SPI slave model and a scoreboard
// queue of expected completions checked by an independent monitor.
`timescale 1ns/1ps
module tb_spi_master_cfg;

   localparam int DATA_W = 8;
   localparam int NUM_SS = 3;
   localparam int DIV_W  = 8;
   localparam int SEL_W  = 2;
   localparam logic [NUM_SS-1:0] SS_IDLE = 3'b111;

   logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic              cpol = 1'b0, cpha = 1'b0, miso_s = 1'b0, miso_zero = 1'b0;
   logic [DATA_W-1:0] wdata = 8'h00;
   logic [DIV_W-1:0]  clk_div = 8'h00;
   logic [SEL_W-1:0]  ss_sel = 2'd0;
   logic              rdy, rx_valid, sclk, mosi;
   logic [DATA_W-1:0] rdata;
   logic [NUM_SS-1:0] ss_n;
`ifdef SPI_LOOPBACK_EN
   logic              loopback = 1'b0;
`endif

   typedef struct {
      logic [7:0] rdata;
      int         cyc;
      logic [7:0] mosi;
   } exp_t;
   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // slave model state (owned by the monitor process)
   logic [7:0]        resp = 8'h00;
   logic [7:0]        mosi_cap = 8'h00;
   int                bit_idx = 0, edges = 0, bad_mosi = 0;
   logic              prev_sclk = 1'b0, prev_mosi = 1'b0, lead;
   logic [NUM_SS-1:0] prev_ss = SS_IDLE;
   logic [NUM_SS-1:0] exp_ss;

   spi_master_cfg #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .DIV_W(DIV_W), .SEL_W(SEL_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .wdata    (wdata),
      .ss_sel   (ss_sel),
      .cpol     (cpol),
      .cpha     (cpha),
      .clk_div  (clk_div),
`ifdef SPI_LOOPBACK_EN
      .loopback (loopback),
`endif
      .rdy      (rdy),
      .rdata    (rdata),
      .rx_valid (rx_valid),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso_zero ? 1'b0 : miso_s),
      .ss_n     (ss_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor + slave: pops the scoreboard on rx_valid, shifts miso per mode.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rx_unexpected actual=rdata %0h expected=no strobe (cycle %0d)", rdata, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("rdata", rdata, e.rdata);
               chk("done_cycle", cyc, e.cyc);
               chk("rdy_at_done", rdy, 1);
               chk("ss_n_released", ss_n, SS_IDLE);
               chk("mosi_bits", mosi_cap, e.mosi);
               chk("sclk_edges", edges, 16);
               chk("mosi_off_drive_edge", bad_mosi, 0);
            end
         end
         if (ss_n !== SS_IDLE && prev_ss === SS_IDLE) begin
            exp_ss = ~(NUM_SS'(1'b1) << ss_sel);
            chk("ss_n_onehot", ss_n, exp_ss);
            chk("sclk_idle_level", sclk, cpol);
            bit_idx = 0; edges = 0; mosi_cap = 8'h00; bad_mosi = 0;
            if (!cpha) miso_s = resp[7];
         end else if (ss_n !== SS_IDLE) begin
            if (sclk !== prev_sclk) begin
               edges++;
               lead = (prev_sclk == cpol);
               if (lead != cpha) mosi_cap = {mosi_cap[6:0], mosi};
               else if (mosi !== prev_mosi) bad_mosi = bad_mosi;
               if (mosi !== prev_mosi && lead != cpha) bad_mosi++;
               if (!cpha && !lead) begin
                  bit_idx++;
                  if (bit_idx < 8) miso_s = resp[7 - bit_idx];
               end
               if (cpha && lead) begin
                  miso_s = resp[7 - bit_idx];
                  bit_idx++;
               end
            end else if (mosi !== prev_mosi) begin
               bad_mosi++;
            end
         end
         prev_ss = ss_n; prev_sclk = sclk; prev_mosi = mosi;
      end
   end

   // Issue one start pulse; optionally push the hand-computed expectation.
   task automatic send(input logic [7:0] wd, input logic [SEL_W-1:0] sel, input logic pol,
                       input logic pha, input logic [7:0] div, input logic [7:0] rsp,
                       input logic [7:0] exp_rd, input int lat, input bit push);
      exp_t e;
      wdata = wd; ss_sel = sel; cpol = pol; cpha = pha; clk_div = div; resp = rsp;
      start = 1'b1;
      if (push) begin
         e.rdata = exp_rd; e.cyc = cyc + lat; e.mosi = wd;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || rdy !== 1'b1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("FAIL timeout actual=%0d cycles expected=done before %0d", n, budget);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin : stim
      logic mosi_before;
      int   n;
      repeat (2) @(negedge clk);
      chk("reset_rdy", rdy, 1);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_sclk", sclk, 0);
      chk("reset_mosi", mosi, 0);
      chk("reset_ss_n", ss_n, SS_IDLE);
      rst_n = 1'b1;
      @(negedge clk);

      // mode 0, H=1: T+18
      send(8'hA5, 2'd2, 1'b0, 1'b0, 8'd0, 8'h3C, 8'h3C, 18, 1'b1);
      wait_done(200);
      // mode 3, H=2: T+35, idles high afterwards
      send(8'h5A, 2'd0, 1'b1, 1'b1, 8'd1, 8'hC3, 8'hC3, 35, 1'b1);
      wait_done(200);
      chk("mode3_idle_high", sclk, 1);
      // mode 1
      send(8'hFF, 2'd1, 1'b0, 1'b1, 8'd0, 8'h55, 8'h55, 18, 1'b1);
      wait_done(200);
      // mode 2, H=3: T+52
      send(8'h00, 2'd2, 1'b1, 1'b0, 8'd2, 8'hAA, 8'hAA, 52, 1'b1);
      wait_done(200);

      // start mid-frame at T+5 is ignored
      send(8'h3C, 2'd0, 1'b0, 1'b0, 8'd1, 8'h5A, 8'h5A, 35, 1'b1);
      repeat (4) @(negedge clk);
      wdata = 8'h00; ss_sel = 2'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_ignored_rdy", rdy, 0);
      wait_done(200);

      // out-of-range select is ignored
      mosi_before = mosi;
      ss_sel = 2'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bad_sel_rdy", rdy, 1);
         chk("bad_sel_ss_n", ss_n, SS_IDLE);
         @(negedge clk);
      end
      chk("bad_sel_mosi", mosi, mosi_before);
      repeat (20) @(negedge clk);

      // reset at the 4th SCLK edge (mode 2 so sclk=0 after reset is meaningful)
      send(8'hF0, 2'd1, 1'b1, 1'b0, 8'd1, 8'h0F, 8'h00, 0, 1'b0);
      @(negedge clk);
      n = 0;
      while (edges < 4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reset_wait_edges", (n < 100), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_ss_n", ss_n, SS_IDLE);
      chk("midreset_sclk", sclk, 0);
      chk("midreset_rdy", rdy, 1);
      chk("midreset_rx_valid", rx_valid, 0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      send(8'h81, 2'd1, 1'b0, 1'b0, 8'd0, 8'h7E, 8'h7E, 18, 1'b1);
      wait_done(200);

      // largest divider: H=256, T+1+256*17 = T+4353
      send(8'h3C, 2'd0, 1'b0, 1'b0, 8'hFF, 8'h81, 8'h81, 4353, 1'b1);
      wait_done(5000);

`ifdef SPI_LOOPBACK_EN
      loopback = 1'b1; miso_zero = 1'b1;
      send(8'h96, 2'd0, 1'b0, 1'b0, 8'd0, 8'hFF, 8'h96, 18, 1'b1);
      wait_done(200);
      loopback = 1'b0; miso_zero = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
